// File: rtl/ipml_fifo_unpack_reader.sv
// Unpacks wide prefetch-FIFO words into narrow lanes with a valid/ready output.
// Two-state FSM holds one word and steps a lane index; the next word is popped on the last lane.
module ipml_fifo_unpack_reader #(
  parameter int c_IN_WIDTH  = 32,
  parameter int c_OUT_WIDTH = 8,
  parameter int c_LSB_FIRST = 1
) (
  input  logic                   rd_clk,
  input  logic                   rd_rst,
  input  logic [c_IN_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_vld,
  output logic                   fifo_rd_en,
  output logic [c_OUT_WIDTH-1:0] out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   out_last,
  output logic [15:0]            word_cnt
);

  localparam int RATIO  = c_IN_WIDTH / c_OUT_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                  state;
  logic [LANE_W-1:0]       lane;
  logic [c_IN_WIDTH-1:0]   hold_word;
  logic                    word_xfer;
  logic                    lane_xfer;

  // Lane 0 is the LS slice when c_LSB_FIRST is set, otherwise the MS slice.
  function automatic logic [c_OUT_WIDTH-1:0] pick_lane(
    input logic [c_IN_WIDTH-1:0] word,
    input logic [LANE_W-1:0]     idx
  );
    int pos;
    pos = (c_LSB_FIRST != 0) ? int'(idx) : (RATIO - 1 - int'(idx));
    return word[pos*c_OUT_WIDTH +: c_OUT_WIDTH];
  endfunction

  assign out_vld    = (state == HOLD);
  assign out_last   = (state == HOLD) && (lane == LAST_LANE);
  assign out_data   = (state == HOLD) ? pick_lane(hold_word, lane) : '0;
  assign lane_xfer  = out_vld & out_rdy;
  assign fifo_rd_en = fifo_rd_vld & ((state == EMPTY) | (lane_xfer & out_last));
  assign word_xfer  = fifo_rd_en & fifo_rd_vld;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state     <= EMPTY;
      lane      <= '0;
      hold_word <= '0;
      word_cnt  <= '0;
    end else begin
      if (word_xfer)
        word_cnt <= word_cnt + 16'd1;
      case (state)
        EMPTY: begin
          if (word_xfer) begin
            hold_word <= fifo_rd_data;
            lane      <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (lane_xfer) begin
            if (lane != LAST_LANE) begin
              lane <= lane + 1'b1;
            end else if (word_xfer) begin
              // Back-to-back word: reload without a bubble.
              hold_word <= fifo_rd_data;
              lane      <= '0;
            end else begin
              lane  <= '0;
              state <= EMPTY;
            end
          end
        end
        default: begin
          state <= EMPTY;
          lane  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipml_fifo_unpack_reader.sv
// Directed bench for ipml_fifo_unpack_reader: LSB-first and MSB-first instances share stimulus.
module tb_ipml_fifo_unpack_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_rd_vld = 1'b0;
  logic        out_rdy = 1'b0;

  logic        fifo_rd_en, out_vld, out_last;
  logic [7:0]  out_data;
  logic [15:0] word_cnt;
  logic        m_fifo_rd_en, m_out_vld, m_out_last;
  logic [7:0]  m_out_data;
  logic [15:0] m_word_cnt;

  int checks = 0;
  int failures = 0;
  logic [63:0] pair;

  ipml_fifo_unpack_reader dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_last(out_last), .word_cnt(word_cnt)
  );

  ipml_fifo_unpack_reader #(.c_IN_WIDTH(32), .c_OUT_WIDTH(8), .c_LSB_FIRST(0)) dut_msb (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_data(fifo_rd_data), .fifo_rd_vld(fifo_rd_vld),
    .fifo_rd_en(m_fifo_rd_en), .out_data(m_out_data), .out_vld(m_out_vld), .out_rdy(out_rdy),
    .out_last(m_out_last), .word_cnt(m_word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic lane_chk(input string tag, input logic [7:0] exp, input logic last);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    chk({tag, "_vld"}, 32'(out_vld), 32'd1);
    chk({tag, "_last"}, 32'(out_last), 32'(last));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge rd_clk);
    #1;
    chk("rst_vld", 32'(out_vld), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_en", 32'(fifo_rd_en), 32'd0);
    rd_rst = 1'b0;
    tick();
    chk("idle_vld", 32'(out_vld), 32'd0);

    // Single word, both lane orders
    fifo_rd_data = 32'h44332211;
    fifo_rd_vld  = 1'b1;
    out_rdy      = 1'b1;
    #1;
    chk("t1_pop_en", 32'(fifo_rd_en), 32'd1);
    tick();
    fifo_rd_vld = 1'b0;
    #1;
    lane_chk("t1_l0", 8'h11, 1'b0);
    chk("t1_m_l0", 32'(m_out_data), 32'h44);
    chk("t1_cnt", 32'(word_cnt), 32'd1);
    tick();
    lane_chk("t1_l1", 8'h22, 1'b0);
    chk("t1_m_l1", 32'(m_out_data), 32'h33);
    tick();
    lane_chk("t1_l2", 8'h33, 1'b0);
    chk("t1_m_l2", 32'(m_out_data), 32'h22);
    tick();
    lane_chk("t1_l3", 8'h44, 1'b1);
    chk("t1_m_l3", 32'(m_out_data), 32'h11);
    chk("t1_m_last", 32'(m_out_last), 32'd1);
    chk("t1_l3_en", 32'(fifo_rd_en), 32'd0);
    tick();
    chk("t1_end_vld", 32'(out_vld), 32'd0);
    chk("t1_end_data", 32'(out_data), 32'd0);
    chk("t1_m_end_vld", 32'(m_out_vld), 32'd0);
    chk("t1_end_cnt", 32'(word_cnt), 32'd1);
    chk("t1_m_end_cnt", 32'(m_word_cnt), 32'd1);

    // Two words back to back, no bubble
    pair = 64'h88776655_44332211;
    fifo_rd_data = 32'h44332211;
    fifo_rd_vld  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) fifo_rd_data = 32'h88776655;
      if (i == 4) fifo_rd_vld = 1'b0;
      #1;
      lane_chk("t2_lane", pair[i*8 +: 8], (i == 3) || (i == 7));
      chk("t2_en", 32'(fifo_rd_en), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t2_cnt", 32'(word_cnt), 32'd3);
    tick();
    chk("t2_end_vld", 32'(out_vld), 32'd0);

    // Back-pressure on lane 1
    fifo_rd_data = 32'h44332211;
    fifo_rd_vld  = 1'b1;
    tick();
    fifo_rd_vld = 1'b0;
    #1;
    lane_chk("t3_l0", 8'h11, 1'b0);
    tick();
    out_rdy     = 1'b0;
    fifo_rd_vld = 1'b1;
    #1;
    lane_chk("t3_stall0", 8'h22, 1'b0);
    chk("t3_stall0_en", 32'(fifo_rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      lane_chk("t3_stall", 8'h22, 1'b0);
      chk("t3_stall_en", 32'(fifo_rd_en), 32'd0);
    end
    out_rdy     = 1'b1;
    fifo_rd_vld = 1'b0;
    tick();
    lane_chk("t3_l2", 8'h33, 1'b0);
    tick();
    lane_chk("t3_l3", 8'h44, 1'b1);
    tick();
    chk("t3_end_vld", 32'(out_vld), 32'd0);
    chk("t3_cnt", 32'(word_cnt), 32'd4);

    // Reset pulse mid-word
    fifo_rd_vld = 1'b1;
    tick();
    fifo_rd_vld = 1'b0;
    #1;
    lane_chk("t4_l0", 8'h11, 1'b0);
    chk("t4_cnt", 32'(word_cnt), 32'd5);
    tick();
    tick();
    lane_chk("t4_l2", 8'h33, 1'b0);
    #1;
    rd_rst = 1'b1;
    #1;
    chk("t4_rst_vld", 32'(out_vld), 32'd0);
    chk("t4_rst_data", 32'(out_data), 32'd0);
    chk("t4_rst_last", 32'(out_last), 32'd0);
    chk("t4_rst_cnt", 32'(word_cnt), 32'd0);
    tick();
    rd_rst       = 1'b0;
    fifo_rd_data = 32'hDDCCBBAA;
    fifo_rd_vld  = 1'b1;
    #1;
    chk("t4_post_vld", 32'(out_vld), 32'd0);
    chk("t4_post_en", 32'(fifo_rd_en), 32'd1);
    tick();
    fifo_rd_vld = 1'b0;
    #1;
    lane_chk("t4_new_l0", 8'hAA, 1'b0);
    chk("t4_new_cnt", 32'(word_cnt), 32'd1);
    tick();
    lane_chk("t4_new_l1", 8'hBB, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
